// File: rtl/fpu_pkg.sv
// Shared opcode, flag and state definitions for the FPU command sequencer.
package fpu_pkg;

  localparam logic [1:0] OP_ADDSUB  = 2'b00;
  localparam logic [1:0] OP_CORDIC  = 2'b01;
  localparam logic [1:0] OP_MULT    = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam int unsigned FLAG_OVF     = 0;
  localparam int unsigned FLAG_UNF     = 1;
  localparam int unsigned FLAG_NAN     = 2;
  localparam int unsigned FLAG_ILLEGAL = 3;
  localparam int unsigned FLAG_TIMEOUT = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BEGIN,
    S_WAIT,
    S_ACK
  } seq_state_e;

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// Command, FPU-side and result signals of the sequencer; master is the sequencer view.
interface fpu_op_sequencer_if #(
  parameter int unsigned W = 64
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_region;
  logic [1:0]   cmd_rmode;
  logic [W-1:0] cmd_data1;
  logic [W-1:0] cmd_data2;

  logic         fpu_begin;
  logic         fpu_ack;
  logic [2:0]   fpu_operation;
  logic [1:0]   fpu_region;
  logic [1:0]   fpu_rmode;
  logic [W-1:0] fpu_data1;
  logic [W-1:0] fpu_data2;
  logic         fpu_ready;
  logic [W-1:0] fpu_result;
  logic         fpu_ovf;
  logic         fpu_unf;
  logic         fpu_nan;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic [4:0]   res_flags;

  modport master (
    input  cmd_valid, cmd_op, cmd_region, cmd_rmode, cmd_data1, cmd_data2,
    output cmd_ready,
    output fpu_begin, fpu_ack, fpu_operation, fpu_region, fpu_rmode, fpu_data1, fpu_data2,
    input  fpu_ready, fpu_result, fpu_ovf, fpu_unf, fpu_nan,
    output res_valid, res_data, res_flags,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_region, cmd_rmode, cmd_data1, cmd_data2,
    input  cmd_ready,
    input  fpu_begin, fpu_ack, fpu_operation, fpu_region, fpu_rmode, fpu_data1, fpu_data2,
    output fpu_ready, fpu_result, fpu_ovf, fpu_unf, fpu_nan,
    input  res_valid, res_data, res_flags,
    output res_ready
  );
endinterface

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO with extra-MSB pointers; wr_ready is registered from the next fill state.
module fpu_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             wr_ready
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic             full, full_nxt, do_push, do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_comb begin
    wr_ptr_nxt = do_push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_nxt = do_pop  ? rd_ptr + 1'b1 : rd_ptr;
    full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                 (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_ready <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      wr_ready <= !full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fpu_op_sequencer.sv
// Buffers FPU requests, drives begin/ack pulses with stable operands, and registers
// each result with its flags behind a valid/ready handshake; hung units time out.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned W         = 64,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TO_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 rst,
  fpu_op_sequencer_if.master  bus
);
  localparam int unsigned PW = 7 + 2 * W;
  localparam int unsigned CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [PW-1:0] fifo_wdata, fifo_rdata;
  logic          fifo_empty, fifo_pop, cmd_push;

  seq_state_e    state, state_nxt;
  logic [2:0]    op_q;
  logic [1:0]    region_q, rmode_q;
  logic [W-1:0]  data1_q, data2_q;
  logic [CW-1:0] cnt;

  logic          res_valid_q;
  logic [W-1:0]  res_data_q;
  logic [4:0]    res_flags_q;

  logic          res_free, timed_out, capture, cnt_clr, cnt_inc;
  logic [W-1:0]  cap_data;
  logic [4:0]    cap_flags;

  assign cmd_push   = bus.cmd_valid && bus.cmd_ready;
  assign fifo_wdata = {bus.cmd_op, bus.cmd_region, bus.cmd_rmode, bus.cmd_data1, bus.cmd_data2};

  fpu_cmd_fifo #(.WIDTH(PW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cmd_push),
    .pop      (fifo_pop),
    .wdata    (fifo_wdata),
    .rdata    (fifo_rdata),
    .empty    (fifo_empty),
    .wr_ready (bus.cmd_ready)
  );

  // A consume in the same cycle frees the register for a new capture.
  assign res_free  = !res_valid_q || bus.res_ready;
  assign timed_out = (cnt == CW'(TO_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    capture   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cap_data  = '0;
    cap_flags = '0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (op_q[2:1] == OP_ILLEGAL) begin
          if (res_free) begin
            capture                 = 1'b1;
            cap_flags[FLAG_ILLEGAL] = 1'b1;
            state_nxt               = S_IDLE;
          end
        end else begin
          state_nxt = S_BEGIN;
        end
      end
      S_BEGIN: begin
        cnt_clr   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Counter freezes whenever the unit is done but the result cannot be stored.
        if (bus.fpu_ready) begin
          if (res_free) begin
            capture             = 1'b1;
            cap_data            = bus.fpu_result;
            cap_flags[FLAG_NAN] = bus.fpu_nan;
            cap_flags[FLAG_UNF] = bus.fpu_unf;
            cap_flags[FLAG_OVF] = bus.fpu_ovf;
            state_nxt           = S_ACK;
          end
        end else if (timed_out) begin
          if (res_free) begin
            capture                 = 1'b1;
            cap_flags[FLAG_TIMEOUT] = 1'b1;
            state_nxt               = S_ACK;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q        <= '0;
      region_q    <= '0;
      rmode_q     <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      cnt         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
    end else begin
      if (fifo_pop) {op_q, region_q, rmode_q, data1_q, data2_q} <= fifo_rdata;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (capture) begin
        res_valid_q <= 1'b1;
        res_data_q  <= cap_data;
        res_flags_q <= cap_flags;
      end else if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.fpu_begin     = (state == S_BEGIN);
  assign bus.fpu_ack       = (state == S_ACK);
  assign bus.fpu_operation = op_q;
  assign bus.fpu_region    = region_q;
  assign bus.fpu_rmode     = rmode_q;
  assign bus.fpu_data1     = data1_q;
  assign bus.fpu_data2     = data2_q;
  assign bus.res_valid     = res_valid_q;
  assign bus.res_data      = res_data_q;
  assign bus.res_flags     = res_flags_q;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Randomized and directed checks of fpu_op_sequencer against a queue-based reference model.
module tb_fpu_op_sequencer;
  import fpu_pkg::*;

  localparam int unsigned W = 64, DEPTH = 4, TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpu_op_sequencer_if #(.W(W)) bus ();
  fpu_op_sequencer #(.W(W), .DEPTH(DEPTH), .TO_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]   op;
    logic [1:0]   region;
    logic [1:0]   rmode;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] res;
    logic [2:0]   fl;
    bit           hang;
    int unsigned  lat;
  } cmd_t;

  typedef struct {
    logic [W-1:0] data;
    logic [4:0]   flags;
  } res_t;

  cmd_t issue_q[$];
  res_t exp_q[$];
  int   errors = 0, checks = 0, cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic res_t expect_of(input cmd_t c);
    res_t r;
    if (c.op[2:1] == 2'b11) begin r.data = '0; r.flags = 5'b01000; end
    else if (c.hang)        begin r.data = '0; r.flags = 5'b10000; end
    else                    begin r.data = c.res; r.flags = {2'b00, c.fl}; end
    return r;
  endfunction

  function automatic cmd_t mk(input logic [2:0] op, input logic [W-1:0] d1, input logic [W-1:0] d2,
                              input logic [W-1:0] res, input logic [2:0] fl, input bit hang,
                              input int unsigned lat);
    cmd_t c;
    c.op = op; c.d1 = d1; c.d2 = d2; c.res = res; c.fl = fl; c.hang = hang; c.lat = lat;
    c.region = 2'($urandom_range(0, 3));
    c.rmode  = 2'($urandom_range(0, 3));
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk(3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
              $urandom_range(0, 10));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output consumer: fixed level or random backpressure.
  bit rr_rand = 1'b0, rr_level = 1'b1;
  always @(posedge clk) begin
    #1;
    bus.res_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_level;
  end

  // FPU stub: takes the next issued command on begin, answers after its latency.
  cmd_t        cur;
  bit          cur_hang = 1'b0, busy = 1'b0;
  int unsigned lat_left = 0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      busy = 1'b0;
      bus.fpu_ready = 1'b0; bus.fpu_result = '0;
      bus.fpu_ovf = 1'b0; bus.fpu_unf = 1'b0; bus.fpu_nan = 1'b0;
    end else begin
      if (bus.fpu_ack) begin bus.fpu_ready = 1'b0; busy = 1'b0; end
      if (bus.fpu_begin) begin
        if (issue_q.size() == 0) begin
          check("begin_unexpected", 1, 0);
          cur.hang = 1'b1;
        end else begin
          cur = issue_q.pop_front();
          check("begin_op", bus.fpu_operation, cur.op);
          check("begin_d1", bus.fpu_data1, cur.d1);
          check("begin_d2", bus.fpu_data2, cur.d2);
          check("begin_rgn_rm", {bus.fpu_region, bus.fpu_rmode}, {cur.region, cur.rmode});
        end
        cur_hang = cur.hang; busy = 1'b1; lat_left = cur.lat;
      end else if (busy && !bus.fpu_ready && !cur_hang) begin
        if (lat_left == 0) begin
          bus.fpu_ready = 1'b1; bus.fpu_result = cur.res;
          {bus.fpu_nan, bus.fpu_unf, bus.fpu_ovf} = cur.fl;
        end else lat_left--;
      end
    end
  end

  // Monitor: pulse protocol, ack latency, result scoreboard.
  int outstanding = 0, n_begins = 0, n_acks = 0;
  int begin_cyc = -1, ack_cyc = -1, rv_rise_cyc = -1, free_rdy_cyc = -1;
  bit prev_rv = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      outstanding = 0; prev_rv = 1'b0;
    end else begin
      if (bus.res_valid && !prev_rv) rv_rise_cyc = cyc;
      prev_rv = bus.res_valid;
      if (bus.fpu_ack) begin
        check("ack_outstanding", outstanding, 1);
        check("ack_res_valid", bus.res_valid, 1);
        check("ack_bus_d1", bus.fpu_data1, cur.d1);
        check("ack_bus_op", bus.fpu_operation, cur.op);
        if (!cur_hang) check("ack_latency", cyc, free_rdy_cyc + 1);
        outstanding = 0; n_acks++; ack_cyc = cyc;
      end else if (bus.fpu_ready && outstanding == 1 && free_rdy_cyc < 0 &&
                   (!bus.res_valid || bus.res_ready)) begin
        free_rdy_cyc = cyc;
      end
      if (bus.fpu_begin) begin
        check("begin_overlap", outstanding, 0);
        outstanding = 1; n_begins++; begin_cyc = cyc; free_rdy_cyc = -1;
      end
      if (bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          res_t e;
          e = exp_q.pop_front();
          check("res_data", bus.res_data, e.data);
          check("res_flags", bus.res_flags, e.flags);
        end
      end
    end
  end

  int acc_cyc = 0;
  task automatic send(input cmd_t c);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = c.op; bus.cmd_region = c.region;
    bus.cmd_rmode = c.rmode; bus.cmd_data1 = c.d1; bus.cmd_data2 = c.d2;
    for (int n = 0; n < 400; n++) begin
      if (bus.cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("cmd_accept", ok, 1);
    if (ok) begin
      if (c.op[2:1] != 2'b11) issue_q.push_back(c);
      exp_q.push_back(expect_of(c));
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && issue_q.size() == 0 && outstanding == 0 && !bus.res_valid) begin
        done = 1'b1; break;
      end
    end
    check("drain", done, 1);
  endtask

  task automatic wait_for_stall(input int nb_target);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (n_begins >= nb_target && outstanding == 1 && bus.res_valid && !bus.fpu_begin) begin
        ok = 1'b1; break;
      end
    end
    check("reach_stall", ok, 1);
  endtask

  initial begin
    int t0, b0, a0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_region = '0; bus.cmd_rmode = '0;
    bus.cmd_data1 = '0; bus.cmd_data2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_pulses", {bus.fpu_begin, bus.fpu_ack}, 0);
    check("rst_res_flags", bus.res_flags, 0);
    @(negedge clk); rst = 1'b1;

    // Single multiply with timing
    b0 = n_begins; a0 = n_acks;
    send(mk({OP_MULT, 1'b0}, 64'h3FF0000000000000, 64'h4000000000000000,
            64'h4000000000000000, 3'b000, 1'b0, 9));
    t0 = acc_cyc;
    drain(200);
    check("mult_begin_cyc", begin_cyc, t0 + 2);
    check("mult_ack_cyc", ack_cyc, t0 + 13);
    check("mult_rv_cyc", rv_rise_cyc, t0 + 13);
    check("mult_pulse_counts", {n_begins - b0, n_acks - a0}, {32'd1, 32'd1});

    // Illegal opcode skips the FPU
    b0 = n_begins;
    send(mk(3'b110, 64'h1234, 64'h5678, 64'hFFFF, 3'b111, 1'b0, 0));
    t0 = acc_cyc;
    drain(100);
    check("illegal_no_begin", n_begins, b0);
    check("illegal_rv_cyc", rv_rise_cyc, t0 + 2);

    // Timeout on a hung unit, then a normal command
    a0 = n_acks;
    send(mk({OP_ADDSUB, 1'b1}, 64'h11, 64'h22, 64'h33, 3'b000, 1'b1, 0));
    t0 = acc_cyc;
    drain(200);
    check("to_ack_cyc", ack_cyc, t0 + TO + 3);
    check("to_rv_cyc", rv_rise_cyc, t0 + TO + 3);
    check("to_ack_once", n_acks - a0, 1);
    send(mk({OP_CORDIC, 1'b1}, 64'hABCD, 64'h0, 64'h7777_0000_1111_2222, 3'b010, 1'b0, 4));
    drain(200);

    // FIFO fill with a slow unit: one command held in flight plus DEPTH queued
    for (int i = 0; i < DEPTH + 1; i++) begin
      send(mk(3'($urandom_range(0, 5)), {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, 3'($urandom_range(0, 7)), 1'b0, 12));
      if (i == DEPTH - 1) check("ready_after_4", bus.cmd_ready, 1);
    end
    check("full_after_5", bus.cmd_ready, 0);
    send(mk(3'b001, 64'h1, 64'h2, 64'h3, 3'b001, 1'b0, 1));
    drain(600);

    // Backpressure holds WAIT with no ack and no timeout
    rr_level = 1'b0;
    @(posedge clk);
    send(mk(3'b000, 64'hA, 64'hB, 64'hC0FFEE, 3'b100, 1'b0, 2));
    send(mk(3'b101, 64'hD, 64'hE, 64'hBEEF00, 3'b001, 1'b0, 2));
    wait_for_stall(n_begins + 2);
    a0 = n_acks;
    repeat (3 * TO) @(negedge clk);
    check("bp_no_ack", n_acks, a0);
    check("bp_hold_valid", bus.res_valid, 1);
    check("bp_ready_held", bus.fpu_ready, 1);
    rr_level = 1'b1;
    drain(200);

    // Asynchronous reset while waiting on the unit
    rr_level = 1'b0;
    @(posedge clk);
    send(mk(3'b100, 64'h55, 64'h66, 64'hDEAD_BEEF_0000_1234, 3'b101, 1'b0, 1));
    send(mk(3'b010, 64'h0123_4567_89AB_CDEF, 64'h9, 64'h42, 3'b000, 1'b0, 12));
    wait_for_stall(n_begins + 2);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("arst_res_valid", bus.res_valid, 0);
    check("arst_res_data", bus.res_data, 0);
    check("arst_res_flags", bus.res_flags, 0);
    check("arst_pulses", {bus.fpu_begin, bus.fpu_ack}, 0);
    check("arst_cmd_ready", bus.cmd_ready, 0);
    check("arst_fpu_bus", {bus.fpu_operation, bus.fpu_data1}, 0);
    issue_q.delete(); exp_q.delete();
    rr_level = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(mk(3'b000, 64'h77, 64'h88, 64'h99, 3'b011, 1'b0, 3));
    drain(200);

    // Randomized traffic with random backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(rand_cmd());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rr_rand = 1'b0; rr_level = 1'b1;
    drain(5000);

    check("all_acked", outstanding, 0);
    check("exp_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
